// File: rtl/uart_out_port_if.sv
// CPU-side write port and status of the UART transmitter.
// The CPU (master) drives the write strobe and data byte. The transmitter (slave)
// returns the serial line and the status flags.
interface uart_out_port_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          _uart_in;    // active-low write strobe
  logic [7:0]    data_in;     // byte qualified by _uart_in
  logic          txd;         // 8N1 serial line, idle high
  logic          _flag_do;    // high only while the FIFO is full
  logic          busy;        // frame on the line or bytes queued
  logic          overrun;     // sticky: a write hit a full FIFO
  logic [CW-1:0] fifo_count;  // queued bytes, not counting the shifter

  modport master (
    output _uart_in, data_in,
    input  txd, _flag_do, busy, overrun, fifo_count
  );

  modport slave (
    input  _uart_in, data_in,
    output txd, _flag_do, busy, overrun, fifo_count
  );
endinterface

// File: rtl/uart_out_port.sv
// UART transmit port: a byte FIFO fed by CPU writes, drained by an 8N1 serialiser.
// Every output comes straight from a flop. A frame is exactly 10*CLKS_PER_BIT
// cycles. Back-to-back frames follow each other with no idle bit between them.
module uart_out_port #(
  parameter int CLKS_PER_BIT = 4,   // 2..255
  parameter int FIFO_DEPTH   = 4    // power of 2, 2..16
) (
  input  logic           clk,
  input  logic           reset,     // synchronous, active-high
  uart_out_port_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [7:0]    BAUD_MAX = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          flag_q;
  logic          overrun_q;

  // Transmitter state
  state_t        state_q;
  logic [7:0]    baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          busy_q;

  // Per-edge strobes
  logic          full;
  logic          push;
  logic          drop;
  logic          baud_done;
  logic          pop;

  // Decode this edge's push, pop and drop, and the count that follows from them.
  // NOTE: combinational logic uses blocking '=' so later lines see earlier results.
  // Sequential state below uses '<=' so all flops update together.
  always_comb begin
    // NOTE: every output is assigned unconditionally here, so no latch can be inferred.
    full      = (count_q == FULL);
    push      = !bus._uart_in && !full;
    drop      = !bus._uart_in && full;
    baud_done = (baud_q == BAUD_MAX);
    // A pop happens when IDLE sees queued data, or when a STOP bit ends with data queued.
    // "full" is taken before the pop, so a write on a popping edge of a full FIFO is still dropped.
    pop       = (count_q != '0) &&
                ((state_q == IDLE) || ((state_q == STOP) && baud_done));
    count_d   = count_q + CW'(push) - CW'(pop);
  end

  // Byte storage.
  // NOTE: the storage array has no reset. count and the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // FIFO pointers, count and the full and overrun flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      flag_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // The pointers are AW bits wide and FIFO_DEPTH is a power of 2,
      // so they wrap on their own.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      flag_q  <= (count_d == FULL);
      if (drop) overrun_q <= 1'b1;
    end
  end

  // Transmit FSM. The line level and busy are registered together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      txd_q   <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= 1'b1;
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            bit_q   <= '0;
            baud_q  <= '0;
            txd_q   <= 1'b0;
            state_q <= START;
          end else begin
            busy_q <= (count_d != '0);
          end
        end

        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end

        DATA: begin
          if (baud_done) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              txd_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end

        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop) begin
              // Chain straight into the next start bit, with no idle bit between frames.
              shift_q <= mem_q[rd_ptr_q];
              bit_q   <= '0;
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
              busy_q  <= (count_d != '0);
            end
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end

        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Flag an undriven or unknown write strobe outside reset.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(bus._uart_in));
    end
  end

  assign bus.txd        = txd_q;
  assign bus._flag_do   = flag_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.fifo_count = count_q;

endmodule
